// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce_pulse block.
// Selects the pulse edge and sizes the per-channel counters.
package debounce_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stability counter, edge pulse.
// Optional auto-repeat is built when DEBOUNCE_PULSE_AUTOREPEAT_EN is defined.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 16,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int REPEAT_DLY  = 1000,
  parameter int REPEAT_PER  = 250
) (
  input  logic clk,
  input  logic clr_n,
  input  logic inp,
  output logic outp,
  output logic level
);

  localparam int CW = cnt_width(STABLE_CYC);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   outp_q, outp_d;
  logic                   s;
  logic                   flip;
  logic                   edge_hit;
  logic                   rep_hit;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], inp};
    cnt_d    = '0;
    level_d  = level_q;
    flip     = 1'b0;
    edge_hit = 1'b0;
    // Any cycle where s agrees with the level restarts the count.
    if (s != level_q) begin
      if (cnt_q == CW'(STABLE_CYC - 1)) begin
        level_d = s;
        flip    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (EDGE_MODE == EDGE_RISE) begin
      edge_hit = flip & level_d;
    end else if (EDGE_MODE == EDGE_FALL) begin
      edge_hit = flip & ~level_d;
    end else begin
      edge_hit = flip;
    end
    outp_d = edge_hit | rep_hit;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      outp_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      outp_q  <= outp_d;
    end
  end

`ifdef DEBOUNCE_PULSE_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW      = cnt_width(REP_MAX);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_per_q, rep_per_d;
  logic          armed_q, armed_d;
  logic          act_now, act_next;

  // Repeats run only after a real press pulse, and stop in the release cycle.
  always_comb begin
    act_now   = (EDGE_MODE == EDGE_FALL) ? ~level_q : level_q;
    act_next  = (EDGE_MODE == EDGE_FALL) ? ~level_d : level_d;
    rep_cnt_d = '0;
    rep_per_d = 1'b0;
    armed_d   = 1'b0;
    rep_hit   = 1'b0;
    if (flip && act_next) begin
      armed_d = 1'b1;
    end else if (armed_q && act_now && act_next) begin
      armed_d   = 1'b1;
      rep_per_d = rep_per_q;
      if (rep_cnt_q == (rep_per_q ? RW'(REPEAT_PER - 1) : RW'(REPEAT_DLY - 1))) begin
        rep_hit   = 1'b1;
        rep_per_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rep_cnt_q <= '0;
      rep_per_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_per_q <= rep_per_d;
      armed_q   <= armed_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DLY > 0) ^ (REPEAT_PER > 0);
  assign rep_hit = 1'b0;
`endif

  assign outp  = outp_q;
  assign level = level_q;

endmodule

// File: rtl/debounce_pulse.sv
// CH independent debounced button channels, each emitting a one-cycle edge pulse.
// Define DEBOUNCE_PULSE_AUTOREPEAT_EN to add hold-to-repeat pulses.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 16,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int REPEAT_DLY  = 1000,
  parameter int REPEAT_PER  = 250
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic [CH-1:0] inp,
  output logic [CH-1:0] outp,
  output logic [CH-1:0] level
);

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_CYC  (STABLE_CYC),
      .EDGE_MODE   (EDGE_MODE),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_PER  (REPEAT_PER)
    ) u_chan (
      .clk   (clk),
      .clr_n (clr_n),
      .inp   (inp[gi]),
      .outp  (outp[gi]),
      .level (level[gi])
    );
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// Bench for debounce_pulse: rising, falling and both-edge instances share inputs.
// Expected level changes are scheduled LAT edges after each settling input change.
module tb_debounce_pulse;

  localparam int CH      = 4;
  localparam int STABLE  = 4;
  localparam int LAT     = 6;
  localparam int REP_DLY = 10;
  localparam int REP_PER = 5;
  localparam int NVEC    = 18;

  typedef struct {
    int   ch;
    logic val;
    int   hold;
    logic settles;
  } vec_t;

  typedef struct {
    int cyc;
    int ch;
  } ev_t;

  logic                 clk = 1'b0;
  logic                 clr_n;
  logic [CH-1:0]        inp;
  logic [2:0][CH-1:0]   outp_m;
  logic [2:0][CH-1:0]   level_m;

  int                   cyc = 0;
  int                   n_pass = 0;
  int                   n_total = 0;
  bit                   mon_en = 1'b0;
  ev_t                  sb[$];
  logic [CH-1:0]        exp_level = '0;
  logic [CH-1:0]        pend = '0;
  int                   rep_next [3][CH];
  vec_t                 vt [NVEC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    debounce_pulse #(
      .CH          (CH),
      .SYNC_STAGES (2),
      .STABLE_CYC  (STABLE),
      .EDGE_MODE   (gi),
      .REPEAT_DLY  (REP_DLY),
      .REPEAT_PER  (REP_PER)
    ) u_dut (
      .clk   (clk),
      .clr_n (clr_n),
      .inp   (inp),
      .outp  (outp_m[gi]),
      .level (level_m[gi])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  task automatic clear_model();
    sb.delete();
    exp_level = '0;
    pend      = '0;
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < CH; c++) rep_next[d][c] = -1;
  endtask

  // Apply v after the next falling edge; channels in settle_mask are expected
  // to reach a new debounced level LAT edges later.
  task automatic drive_vec(input logic [CH-1:0] v, input logic [CH-1:0] settle_mask, input int hold);
    @(negedge clk);
    #2;
    for (int c = 0; c < CH; c++) begin
      if (settle_mask[c] && v[c] != pend[c]) begin
        sb.push_back('{cyc + LAT, c});
        pend[c] = v[c];
      end
    end
    inp = v;
    $display("drive cyc=%0d inp=%b settle=%b hold=%0d", cyc, v, settle_mask, hold);
    repeat (hold - 1) @(negedge clk);
  endtask

  // Scoreboard consumer: every cycle, compare all three instances.
  logic [CH-1:0] chg, newl, exp_p, act_lvl;
  ev_t           ev;
  always @(negedge clk) begin
    if (mon_en) begin
      chg = '0;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        ev = sb.pop_front();
        chg[ev.ch] = 1'b1;
      end
      newl = exp_level ^ chg;
      for (int d = 0; d < 3; d++) begin
        act_lvl = (d == 1) ? ~newl : newl;
        exp_p   = (d == 0) ? (chg & newl) : (d == 1) ? (chg & ~newl) : chg;
`ifdef DEBOUNCE_PULSE_AUTOREPEAT_EN
        for (int c = 0; c < CH; c++) begin
          if (chg[c]) begin
            rep_next[d][c] = act_lvl[c] ? cyc + REP_DLY : -1;
          end else if (rep_next[d][c] == cyc) begin
            exp_p[c] = 1'b1;
            rep_next[d][c] = cyc + REP_PER;
          end
        end
`endif
        chk($sformatf("level_mode%0d", d), 32'(level_m[d]), 32'(newl));
        chk($sformatf("outp_mode%0d", d), 32'(outp_m[d]), 32'(exp_p));
      end
      exp_level = newl;
    end
  end

  initial begin
    logic [CH-1:0] v;
    vt[0]  = '{0, 1'b1, 12, 1'b1};   // clean press
    vt[1]  = '{0, 1'b0, 10, 1'b1};
    vt[2]  = '{1, 1'b1, 2,  1'b0};   // bounce
    vt[3]  = '{1, 1'b0, 2,  1'b0};
    vt[4]  = '{1, 1'b1, 2,  1'b0};
    vt[5]  = '{1, 1'b0, 2,  1'b0};
    vt[6]  = '{1, 1'b1, 12, 1'b1};
    vt[7]  = '{1, 1'b0, 10, 1'b1};
    vt[8]  = '{2, 1'b1, 20, 1'b1};   // press, release after 20
    vt[9]  = '{2, 1'b0, 12, 1'b1};
    vt[10] = '{0, 1'b1, 8,  1'b1};   // glitch while high
    vt[11] = '{0, 1'b0, 3,  1'b0};
    vt[12] = '{0, 1'b1, 8,  1'b0};
    vt[13] = '{0, 1'b0, 10, 1'b1};
    vt[14] = '{3, 1'b1, 3,  1'b0};   // one short of STABLE
    vt[15] = '{3, 1'b0, 6,  1'b0};
    vt[16] = '{3, 1'b1, 4,  1'b1};   // exactly STABLE
    vt[17] = '{3, 1'b0, 8,  1'b1};

    clear_model();
    clr_n = 1'b0;
    inp   = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_level_mode%0d", d), 32'(level_m[d]), 32'h0);
      chk($sformatf("reset_outp_mode%0d", d), 32'(outp_m[d]), 32'h0);
    end
    #2;
    clr_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      v = inp;
      v[vt[i].ch] = vt[i].val;
      drive_vec(v, vt[i].settles ? (CH'(1) << vt[i].ch) : '0, vt[i].hold);
    end

    // All channels at once
    drive_vec(4'b1111, 4'b1111, 12);
    drive_vec(4'b0000, 4'b1111, 12);

    // Long hold (repeat pulses when the feature is built in)
    drive_vec(4'b0001, 4'b0001, 30);
    drive_vec(4'b0000, 4'b0001, 14);

    // Reset while channel 3 is mid-count and channel 0 is already high
    drive_vec(4'b0001, 4'b0001, 10);
    drive_vec(4'b1001, 4'b0000, 3);
    @(negedge clk);
    #2;
    clr_n  = 1'b0;
    mon_en = 1'b0;
    clear_model();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("async_clr_level_mode%0d", d), 32'(level_m[d]), 32'h0);
      chk($sformatf("async_clr_outp_mode%0d", d), 32'(outp_m[d]), 32'h0);
    end
    repeat (2) @(negedge clk);
    #2;
    clr_n = 1'b1;
    for (int c = 0; c < CH; c++) begin
      if (inp[c]) begin
        sb.push_back('{cyc + LAT, c});
        pend[c] = 1'b1;
      end
    end
    mon_en = 1'b1;
    repeat (12) @(negedge clk);

    drive_vec(4'b0000, 4'b1111, 14);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
